tcdm_rr_arbiter: RTL and testbench



---
 rtl/tcdm_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_tcdm_rr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_rr_arbiter.sv
// tcdm_rr_arbiter: round-robin arbiter sharing one TCDM memory port between
// N_REQ masters. An in-order ID FIFO routes each response back to the master
// whose request produced it.
// Optional build macro TCDM_ARB_PERF_EN adds per-master stall counters
// (stall_cnt_o) and their synchronous clear (perf_clr_i).
module tcdm_rr_arbiter #(
    parameter int unsigned N_REQ           = 3,
    parameter int unsigned AW              = 32,
    parameter int unsigned DW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              in_req,
    input  logic [N_REQ-1:0][AW-1:0]      in_add,
    input  logic [N_REQ-1:0]              in_wen,
    input  logic [N_REQ-1:0][DW/8-1:0]    in_be,
    input  logic [N_REQ-1:0][DW-1:0]      in_data,
    output logic [N_REQ-1:0]              in_gnt,
    output logic [DW-1:0]                 in_r_data,
    output logic [N_REQ-1:0]              in_r_valid,
    output logic                          out_req,
    output logic [AW-1:0]                 out_add,
    output logic                          out_wen,
    output logic [DW/8-1:0]               out_be,
    output logic [DW-1:0]                 out_data,
    input  logic                          out_gnt,
    input  logic [DW-1:0]                 out_r_data,
    input  logic                          out_r_valid,
    output logic                          busy_o,
    output logic                          err_o
`ifdef TCDM_ARB_PERF_EN
    ,
    input  logic                          perf_clr_i,
    output logic [N_REQ-1:0][31:0]        stall_cnt_o
`endif
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IW-1:0] fifo_d [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [IW-1:0] sel;
    logic          found;
    int unsigned   scan_idx;
    logic          full;
    logic          push;
    logic          pop;
    logic [IW-1:0] head_id;

    assign full    = (count_q == CW'(MAX_OUTSTANDING));
    assign out_req = (|in_req) & ~full;
    assign push    = out_req & out_gnt;
    assign pop     = out_r_valid & (count_q != '0);
    assign head_id = fifo_q[rd_ptr_q];

    // Round-robin scan starting at rr_ptr; first requesting master wins.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!found && in_req[scan_idx]) begin
                found = 1'b1;
                sel   = IW'(scan_idx);
            end
        end
    end

    // Forward the selected master's fields and route grant / response strobes.
    always_comb begin
        out_add    = in_add[sel];
        out_wen    = in_wen[sel];
        out_be     = in_be[sel];
        out_data   = in_data[sel];
        in_gnt     = '0;
        in_r_valid = '0;
        in_r_data  = out_r_data;
        if (push) begin
            in_gnt[sel] = 1'b1;
        end
        if (pop) begin
            in_r_valid[head_id] = 1'b1;
        end
    end

    // Next state for priority pointer, ID FIFO, occupancy and error flag.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (out_r_valid & (count_q == '0));
        if (push) begin
            rr_ptr_d         = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards any in-flight IDs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign busy_o = (count_q != '0);
    assign err_o  = err_q;

`ifdef TCDM_ARB_PERF_EN
    logic [N_REQ-1:0][31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles each master waits with its request up; saturating, clear wins.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (perf_clr_i) begin
                stall_cnt_d[i] = '0;
            end else if (in_req[i] && !in_gnt[i] && (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Testbench for tcdm_rr_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model of the arbiter.
module tb_tcdm_rr_arbiter;

    localparam int N_REQ = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MO    = 4;
    localparam int BW    = DW / 8;

    logic                       clk_i;
    logic                       rst_ni;
    logic [N_REQ-1:0]           in_req;
    logic [N_REQ-1:0][AW-1:0]   in_add;
    logic [N_REQ-1:0]           in_wen;
    logic [N_REQ-1:0][BW-1:0]   in_be;
    logic [N_REQ-1:0][DW-1:0]   in_data;
    logic [N_REQ-1:0]           in_gnt;
    logic [DW-1:0]              in_r_data;
    logic [N_REQ-1:0]           in_r_valid;
    logic                       out_req;
    logic [AW-1:0]              out_add;
    logic                       out_wen;
    logic [BW-1:0]              out_be;
    logic [DW-1:0]              out_data;
    logic                       out_gnt;
    logic [DW-1:0]              out_r_data;
    logic                       out_r_valid;
    logic                       busy_o;
    logic                       err_o;
`ifdef TCDM_ARB_PERF_EN
    logic                       perf_clr_i;
    logic [N_REQ-1:0][31:0]     stall_cnt_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    tcdm_rr_arbiter #(
        .N_REQ(N_REQ), .AW(AW), .DW(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_req     (in_req),
        .in_add     (in_add),
        .in_wen     (in_wen),
        .in_be      (in_be),
        .in_data    (in_data),
        .in_gnt     (in_gnt),
        .in_r_data  (in_r_data),
        .in_r_valid (in_r_valid),
        .out_req    (out_req),
        .out_add    (out_add),
        .out_wen    (out_wen),
        .out_be     (out_be),
        .out_data   (out_data),
        .out_gnt    (out_gnt),
        .out_r_data (out_r_data),
        .out_r_valid(out_r_valid),
        .busy_o     (busy_o),
        .err_o      (err_o)
`ifdef TCDM_ARB_PERF_EN
        ,
        .perf_clr_i (perf_clr_i),
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic zero_inputs();
        in_req      = '0;
        in_add      = '0;
        in_wen      = '0;
        in_be       = '0;
        in_data     = '0;
        out_gnt     = 1'b0;
        out_r_data  = '0;
        out_r_valid = 1'b0;
`ifdef TCDM_ARB_PERF_EN
        perf_clr_i  = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        zero_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Apply control inputs at the falling edge, settle, return for sampling.
    task automatic drive(input logic [N_REQ-1:0] req, input logic gnt,
                         input logic rv, input logic [DW-1:0] rd);
        @(negedge clk_i);
        in_req      = req;
        out_gnt     = gnt;
        out_r_valid = rv;
        out_r_data  = rd;
        #1;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst_ni = 1'b0;
        #1;
        n_checks++; if (out_req !== 1'b0) $display("FAIL reset_out_req: got %b exp 0", out_req); else n_pass++;
        n_checks++; if (in_gnt !== 3'b000) $display("FAIL reset_in_gnt: got %b exp 000", in_gnt); else n_pass++;
        n_checks++; if (in_r_valid !== 3'b000) $display("FAIL reset_in_r_valid: got %b exp 000", in_r_valid); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b exp 0", err_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk_i);
        in_add[0] = 32'h100;
        in_wen[0] = 1'b1;
        in_be[0]  = 4'hF;
        drive(3'b001, 1'b1, 1'b0, '0);
        n_checks++; if (in_gnt !== 3'b001) $display("FAIL single_gnt: got %b exp 001", in_gnt); else n_pass++;
        n_checks++; if (out_add !== 32'h100) $display("FAIL single_add: got %h exp 00000100", out_add); else n_pass++;
        n_checks++; if (out_wen !== 1'b1) $display("FAIL single_wen: got %b exp 1", out_wen); else n_pass++;
        drive(3'b000, 1'b0, 1'b1, 32'hDEADBEEF);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL single_busy1: got %b exp 1", busy_o); else n_pass++;
        n_checks++; if (in_r_valid !== 3'b001) $display("FAIL single_rvalid: got %b exp 001", in_r_valid); else n_pass++;
        n_checks++; if (in_r_data !== 32'hDEADBEEF) $display("FAIL single_rdata: got %h exp deadbeef", in_r_data); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, '0);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL single_busy0: got %b exp 0", busy_o); else n_pass++;
    endtask

    task automatic test_all_masters();
        logic [N_REQ-1:0] eg, ev;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 1'b1, (k > 0), 32'h1000 + k);
            eg = 3'(1 << (k % 3));
            ev = (k > 0) ? 3'(1 << ((k - 1) % 3)) : 3'b000;
            n_checks++; if (in_gnt !== eg) $display("FAIL all_gnt[%0d]: got %b exp %b", k, in_gnt, eg); else n_pass++;
            n_checks++; if (in_r_valid !== ev) $display("FAIL all_rvalid[%0d]: got %b exp %b", k, in_r_valid, ev); else n_pass++;
        end
        drive(3'b000, 1'b0, 1'b1, 32'h2000);
        n_checks++; if (in_r_valid !== 3'b100) $display("FAIL all_rvalid_last: got %b exp 100", in_r_valid); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, '0);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL all_busy_end: got %b exp 0", busy_o); else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(3'b110, 1'b0, 1'b0, '0);
            n_checks++; if (in_gnt !== 3'b000) $display("FAIL stall_gnt[%0d]: got %b exp 000", k, in_gnt); else n_pass++;
            n_checks++; if (out_req !== 1'b1) $display("FAIL stall_req[%0d]: got %b exp 1", k, out_req); else n_pass++;
        end
        drive(3'b110, 1'b1, 1'b0, '0);
        n_checks++; if (in_gnt !== 3'b010) $display("FAIL stall_first: got %b exp 010", in_gnt); else n_pass++;
        drive(3'b110, 1'b1, 1'b0, '0);
        n_checks++; if (in_gnt !== 3'b100) $display("FAIL stall_second: got %b exp 100", in_gnt); else n_pass++;
        drive(3'b000, 1'b0, 1'b1, 32'h11);
        n_checks++; if (in_r_valid !== 3'b010) $display("FAIL stall_rv1: got %b exp 010", in_r_valid); else n_pass++;
        drive(3'b000, 1'b0, 1'b1, 32'h22);
        n_checks++; if (in_r_valid !== 3'b100) $display("FAIL stall_rv2: got %b exp 100", in_r_valid); else n_pass++;
    endtask

    task automatic test_full();
        logic [N_REQ-1:0] eg;
        logic [N_REQ-1:0] order [5];
        order = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(3'b111, 1'b1, 1'b0, '0);
            eg = 3'(1 << (k % 3));
            n_checks++; if (in_gnt !== eg) $display("FAIL full_gnt[%0d]: got %b exp %b", k, in_gnt, eg); else n_pass++;
        end
        drive(3'b111, 1'b1, 1'b0, '0);
        n_checks++; if (out_req !== 1'b0) $display("FAIL full_req_blocked: got %b exp 0", out_req); else n_pass++;
        n_checks++; if (in_gnt !== 3'b000) $display("FAIL full_gnt_blocked: got %b exp 000", in_gnt); else n_pass++;
        drive(3'b111, 1'b1, 1'b1, 32'h55);
        n_checks++; if (in_r_valid !== 3'b001) $display("FAIL full_pop_rv: got %b exp 001", in_r_valid); else n_pass++;
        n_checks++; if (out_req !== 1'b0) $display("FAIL full_pop_req: got %b exp 0", out_req); else n_pass++;
        drive(3'b111, 1'b1, 1'b0, '0);
        n_checks++; if (out_req !== 1'b1) $display("FAIL full_reopen_req: got %b exp 1", out_req); else n_pass++;
        n_checks++; if (in_gnt !== 3'b010) $display("FAIL full_fifth_gnt: got %b exp 010", in_gnt); else n_pass++;
        // Drain: remaining IDs are 1,2,0 and the fifth grant (1).
        for (int k = 0; k < 4; k++) begin
            drive(3'b000, 1'b0, 1'b1, 32'h60 + k);
            n_checks++; if (in_r_valid !== order[k]) $display("FAIL full_drain[%0d]: got %b exp %b", k, in_r_valid, order[k]); else n_pass++;
        end
        drive(3'b000, 1'b0, 1'b0, '0);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL full_busy_end: got %b exp 0", busy_o); else n_pass++;
    endtask

    task automatic test_err();
        do_reset();
        drive(3'b000, 1'b0, 1'b1, 32'h77);
        n_checks++; if (in_r_valid !== 3'b000) $display("FAIL err_no_rvalid: got %b exp 000", in_r_valid); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive(3'b000, 1'b0, 1'b0, '0);
            n_checks++; if (err_o !== 1'b1) $display("FAIL err_sticky[%0d]: got %b exp 1", k, err_o); else n_pass++;
        end
        // Outstanding request, then reset mid-operation and a stale response.
        drive(3'b001, 1'b1, 1'b0, '0);
        @(negedge clk_i);
        in_req  = '0;
        out_gnt = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (err_o !== 1'b0) $display("FAIL err_async_clear: got %b exp 0", err_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL err_async_busy: got %b exp 0", busy_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(3'b000, 1'b0, 1'b1, 32'h88);
        n_checks++; if (in_r_valid !== 3'b000) $display("FAIL err_stale_rvalid: got %b exp 000", in_r_valid); else n_pass++;
        drive(3'b000, 1'b0, 1'b0, '0);
        n_checks++; if (err_o !== 1'b1) $display("FAIL err_stale_set: got %b exp 1", err_o); else n_pass++;
    endtask

    task automatic test_random();
        int               m_q[$];
        int               m_rr;
        bit               m_err;
        int               msel;
        bit               found, exp_req, hs;
        logic [N_REQ-1:0] eg, ev;
        do_reset();
        m_q.delete();
        m_rr  = 0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            in_req  = N_REQ'($urandom);
            out_gnt = ($urandom_range(0, 3) != 0);
            if (m_q.size() > 0) out_r_valid = $urandom_range(0, 1);
            else                out_r_valid = ($urandom_range(0, 31) == 0);
            out_r_data = $urandom;
            for (int i = 0; i < N_REQ; i++) begin
                in_add[i]  = $urandom;
                in_wen[i]  = $urandom_range(0, 1);
                in_be[i]   = BW'($urandom);
                in_data[i] = $urandom;
            end
            #1;
            found = 1'b0;
            msel  = 0;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && in_req[(m_rr + k) % N_REQ]) begin
                    found = 1'b1;
                    msel  = (m_rr + k) % N_REQ;
                end
            end
            exp_req = found && (m_q.size() < MO);
            hs      = exp_req && out_gnt;
            eg      = hs ? 3'(1 << msel) : 3'b000;
            ev      = (out_r_valid && m_q.size() > 0) ? 3'(1 << m_q[0]) : 3'b000;
            n_checks++; if (out_req !== exp_req) $display("FAIL rnd_req[%0d]: got %b exp %b", cyc, out_req, exp_req); else n_pass++;
            n_checks++; if (in_gnt !== eg) $display("FAIL rnd_gnt[%0d]: got %b exp %b", cyc, in_gnt, eg); else n_pass++;
            n_checks++; if (in_r_valid !== ev) $display("FAIL rnd_rvalid[%0d]: got %b exp %b", cyc, in_r_valid, ev); else n_pass++;
            n_checks++; if (busy_o !== (m_q.size() != 0)) $display("FAIL rnd_busy[%0d]: got %b exp %b", cyc, busy_o, (m_q.size() != 0)); else n_pass++;
            n_checks++; if (err_o !== m_err) $display("FAIL rnd_err[%0d]: got %b exp %b", cyc, err_o, m_err); else n_pass++;
            if (exp_req) begin
                n_checks++;
                if (out_add !== in_add[msel] || out_wen !== in_wen[msel] ||
                    out_be !== in_be[msel] || out_data !== in_data[msel])
                    $display("FAIL rnd_fields[%0d]: got %h/%b/%h/%h exp %h/%b/%h/%h", cyc,
                             out_add, out_wen, out_be, out_data,
                             in_add[msel], in_wen[msel], in_be[msel], in_data[msel]);
                else n_pass++;
            end
            if (ev != 3'b000) begin
                n_checks++; if (in_r_data !== out_r_data) $display("FAIL rnd_rdata[%0d]: got %h exp %h", cyc, in_r_data, out_r_data); else n_pass++;
            end
            if (out_r_valid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else                m_err = 1'b1;
            end
            if (hs) begin
                m_q.push_back(msel);
                m_rr = (msel + 1) % N_REQ;
            end
        end
    endtask

`ifdef TCDM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int k = 0; k < 4; k++) drive(3'b011, 1'b1, 1'b0, '0);
        drive(3'b000, 1'b0, 1'b0, '0);
        n_checks++; if (stall_cnt_o[0] !== 32'd2) $display("FAIL perf_cnt0: got %0d exp 2", stall_cnt_o[0]); else n_pass++;
        n_checks++; if (stall_cnt_o[1] !== 32'd2) $display("FAIL perf_cnt1: got %0d exp 2", stall_cnt_o[1]); else n_pass++;
        n_checks++; if (stall_cnt_o[2] !== 32'd0) $display("FAIL perf_cnt2: got %0d exp 0", stall_cnt_o[2]); else n_pass++;
        @(negedge clk_i);
        perf_clr_i = 1'b1;
        in_req     = 3'b011;
        @(negedge clk_i);
        perf_clr_i = 1'b0;
        in_req     = '0;
        #1;
        n_checks++; if (stall_cnt_o[0] !== 32'd0) $display("FAIL perf_clr0: got %0d exp 0", stall_cnt_o[0]); else n_pass++;
        n_checks++; if (stall_cnt_o[1] !== 32'd0) $display("FAIL perf_clr1: got %0d exp 0", stall_cnt_o[1]); else n_pass++;
    endtask
`endif

    initial begin
        rst_ni = 1'b1;
        zero_inputs();
        test_reset();
        test_single_read();
        test_all_masters();
        test_stall();
        test_full();
        test_err();
        test_random();
`ifdef TCDM_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
